// File: rtl/spi_command_decoder_if.sv
// spi_command_decoder_if
//   Bundles the byte-stream input, sprite-memory write port, draw-request handshake,
//   status and error pulses of spi_command_decoder.
//   Optional: `define SPI_CMD_STATS_EN adds the stat_* counter outputs.
//
//   Signals
//     cs_n, byte_valid, byte_data     byte stream from the SPI byte reader
//     spr_we, spr_id, spr_addr,
//     spr_wdata                       sprite memory write port
//     draw_valid, draw_ready,
//     draw_id, draw_pos               draw-request handshake (FIFO head)
//     busy                            decoder is inside a command
//     err_unknown, err_badid,
//     err_abort, err_overflow         one-cycle error pulses
//     stat_sprites, stat_draws,
//     stat_errors                     saturating counters (SPI_CMD_STATS_EN only)
//
//   Modports
//     slave   the decoder
//     master  the surrounding logic (byte reader, sprite memory, renderer)

interface spi_command_decoder_if #(
    parameter int unsigned NUM_SPRITES  = 16,
    parameter int unsigned SPRITE_BYTES = 512
);
    localparam int unsigned IdW   = $clog2(NUM_SPRITES);
    localparam int unsigned AddrW = $clog2(SPRITE_BYTES);

    logic             cs_n;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             spr_we;
    logic [IdW-1:0]   spr_id;
    logic [AddrW-1:0] spr_addr;
    logic [7:0]       spr_wdata;
    logic             draw_valid;
    logic             draw_ready;
    logic [7:0]       draw_id;
    logic [7:0]       draw_pos;
    logic             busy;
    logic             err_unknown;
    logic             err_badid;
    logic             err_abort;
    logic             err_overflow;
`ifdef SPI_CMD_STATS_EN
    logic [15:0]      stat_sprites;
    logic [15:0]      stat_draws;
    logic [15:0]      stat_errors;
`endif

    modport slave (
        input  cs_n, byte_valid, byte_data, draw_ready,
        output spr_we, spr_id, spr_addr, spr_wdata,
        output draw_valid, draw_id, draw_pos, busy,
        output err_unknown, err_badid, err_abort, err_overflow
`ifdef SPI_CMD_STATS_EN
        , output stat_sprites, stat_draws, stat_errors
`endif
    );

    modport master (
        output cs_n, byte_valid, byte_data, draw_ready,
        input  spr_we, spr_id, spr_addr, spr_wdata,
        input  draw_valid, draw_id, draw_pos, busy,
        input  err_unknown, err_badid, err_abort, err_overflow
`ifdef SPI_CMD_STATS_EN
        , input stat_sprites, stat_draws, stat_errors
`endif
    );
endinterface

// File: rtl/spi_command_decoder.sv
// spi_command_decoder
//   Decodes the host command byte stream coming out of the SPI byte reader.
//     0x00 <id> <SPRITE_BYTES pixels>  : pixels written to sprite memory slot <id>
//     0x01 <id> <pos>                  : {id, pos} queued in a draw-request FIFO
//   Any other opcode pulses err_unknown. cs_n high returns the decoder to the command
//   state; the draw FIFO keeps its contents across an abort.
//   Optional: `define SPI_CMD_STATS_EN adds saturating stat_sprites / stat_draws /
//   stat_errors counters.
//
//   Ports
//     clk    system clock
//     rst_n  synchronous active-low reset (discards partial command, flushes FIFO)
//     bus    spi_command_decoder_if.slave: byte stream in, sprite write port out,
//            draw valid/ready handshake, busy and error pulses

module spi_command_decoder #(
    parameter int unsigned NUM_SPRITES     = 16,
    parameter int unsigned SPRITE_BYTES    = 512,
    parameter int unsigned DRAW_FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_command_decoder_if.slave bus
);
    localparam int unsigned IdW   = $clog2(NUM_SPRITES);
    localparam int unsigned AddrW = $clog2(SPRITE_BYTES);
    localparam int unsigned PtrW  = $clog2(DRAW_FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [AddrW-1:0] LastAddr  = AddrW'(SPRITE_BYTES - 1);
    localparam logic [CntW-1:0]  FifoDepth = CntW'(DRAW_FIFO_DEPTH);

    typedef enum logic [2:0] {
        StCmd,
        StSprId,
        StSprData,
        StDrawId,
        StDrawPos
    } state_e;

    state_e state_q, state_d;

    // Command datapath
    logic [IdW-1:0]   spr_id_q, spr_id_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;
    logic [7:0]       draw_id_lat_q, draw_id_lat_d;

    // Registered outputs
    logic             spr_we_q, spr_we_d;
    logic [AddrW-1:0] spr_addr_q, spr_addr_d;
    logic [7:0]       spr_wdata_q, spr_wdata_d;
    logic             err_unknown_q, err_unknown_d;
    logic             err_badid_q, err_badid_d;
    logic             err_abort_q, err_abort_d;
    logic             err_overflow_q, err_overflow_d;

    // Draw FIFO
    logic [15:0]      mem_q [DRAW_FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push, push_ok, pop, full;
    logic [15:0]      push_entry;

    logic             byte_take;
    logic             id_bad;
    logic             spr_done;

    // A byte arriving together with cs_n high belongs to no frame and is dropped.
    assign byte_take = bus.byte_valid && !bus.cs_n;
    assign id_bad    = {24'd0, bus.byte_data} >= NUM_SPRITES;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StCmd;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (bus.cs_n) begin
            state_d = StCmd;
        end else if (bus.byte_valid) begin
            case (state_q)
                StCmd: begin
                    if (bus.byte_data == 8'h00) begin
                        state_d = StSprId;
                    end else if (bus.byte_data == 8'h01) begin
                        state_d = StDrawId;
                    end
                end
                StSprId:   state_d = StSprData;
                StSprData: if (cnt_q == LastAddr) state_d = StCmd;
                StDrawId:  state_d = StDrawPos;
                StDrawPos: state_d = StCmd;
                default:   state_d = StCmd;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        spr_we_d       = 1'b0;
        spr_addr_d     = spr_addr_q;
        spr_wdata_d    = spr_wdata_q;
        spr_id_d       = spr_id_q;
        cnt_d          = cnt_q;
        discard_d      = discard_q;
        draw_id_lat_d  = draw_id_lat_q;
        push           = 1'b0;
        push_entry     = {draw_id_lat_q, bus.byte_data};
        spr_done       = 1'b0;
        err_unknown_d  = 1'b0;
        err_badid_d    = 1'b0;
        err_abort_d    = bus.cs_n && (state_q != StCmd);
        if (byte_take) begin
            case (state_q)
                StCmd: begin
                    err_unknown_d = (bus.byte_data != 8'h00) && (bus.byte_data != 8'h01);
                end
                StSprId: begin
                    // An invalid id still consumes its full payload, just without writes.
                    if (!id_bad) spr_id_d = bus.byte_data[IdW-1:0];
                    discard_d   = id_bad;
                    err_badid_d = id_bad;
                    cnt_d       = '0;
                end
                StSprData: begin
                    spr_we_d = !discard_q;
                    if (!discard_q) begin
                        spr_addr_d  = cnt_q;
                        spr_wdata_d = bus.byte_data;
                    end
                    cnt_d    = cnt_q + 1'b1;
                    spr_done = (cnt_q == LastAddr);
                end
                StDrawId:  draw_id_lat_d = bus.byte_data;
                StDrawPos: push = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spr_we_q       <= 1'b0;
            spr_addr_q     <= '0;
            spr_wdata_q    <= '0;
            spr_id_q       <= '0;
            cnt_q          <= '0;
            discard_q      <= 1'b0;
            draw_id_lat_q  <= '0;
            err_unknown_q  <= 1'b0;
            err_badid_q    <= 1'b0;
            err_abort_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            spr_we_q       <= spr_we_d;
            spr_addr_q     <= spr_addr_d;
            spr_wdata_q    <= spr_wdata_d;
            spr_id_q       <= spr_id_d;
            cnt_q          <= cnt_d;
            discard_q      <= discard_d;
            draw_id_lat_q  <= draw_id_lat_d;
            err_unknown_q  <= err_unknown_d;
            err_badid_q    <= err_badid_d;
            err_abort_q    <= err_abort_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // ---------------------------------------------------------------- draw FIFO
    assign full           = (count_q == FifoDepth);
    assign pop            = (count_q != '0) && bus.draw_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok        = push && (!full || pop);
    assign err_overflow_d = push && !push_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push_ok) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

    // ---------------------------------------------------------------- optional statistics
`ifdef SPI_CMD_STATS_EN
    logic [15:0] stat_sprites_q, stat_draws_q, stat_errors_q;
    logic        any_err;

    assign any_err = err_unknown_q | err_badid_q | err_abort_q | err_overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_sprites_q <= '0;
            stat_draws_q   <= '0;
            stat_errors_q  <= '0;
        end else begin
            if (spr_done && (stat_sprites_q != 16'hFFFF)) stat_sprites_q <= stat_sprites_q + 16'd1;
            if (push_ok && (stat_draws_q != 16'hFFFF))    stat_draws_q   <= stat_draws_q + 16'd1;
            if (any_err && (stat_errors_q != 16'hFFFF))   stat_errors_q  <= stat_errors_q + 16'd1;
        end
    end

    assign bus.stat_sprites = stat_sprites_q;
    assign bus.stat_draws   = stat_draws_q;
    assign bus.stat_errors  = stat_errors_q;
`endif

    // ---------------------------------------------------------------- output mapping
    assign bus.spr_we       = spr_we_q;
    assign bus.spr_id       = spr_id_q;
    assign bus.spr_addr     = spr_addr_q;
    assign bus.spr_wdata    = spr_wdata_q;
    assign bus.draw_valid   = (count_q != '0);
    // Head is forced to zero while empty so the outputs read 0 out of reset.
    assign bus.draw_id      = (count_q != '0) ? mem_q[rd_ptr_q][15:8] : 8'h00;
    assign bus.draw_pos     = (count_q != '0) ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign bus.busy         = (state_q != StCmd);
    assign bus.err_unknown  = err_unknown_q;
    assign bus.err_badid    = err_badid_q;
    assign bus.err_abort    = err_abort_q;
    assign bus.err_overflow = err_overflow_q;
endmodule
